// File: rtl/mmcm_rst_seq.sv
// mmcm_rst_seq: reset/lock supervisor for the logic-clock MMCM.
//
// Runs on the free-running 200 MHz input clock. Each attempt pulses the MMCM
// reset, then waits for LOCKED with a timeout. Lock must then hold for a
// stable window. After that, the four downstream domain resets are released
// in staggered order: 20M, 25M, 50M, then logic.
// Failed attempts are retried up to MAX_RETRY times; after that the block parks in FAIL.
// Lock loss or a software request restarts the whole sequence.
//
// Ports:
//   clk_gloal_in      free-running input clock
//   hardware_rst_in   asynchronous active-high reset
//   soft_rst_req_in   single-cycle restart request (highest priority)
//   mmcm_locked_in    MMCM LOCKED, asynchronous (synchronized internally)
//   mmcm_rst_out      MMCM RST, active-high
//   rst_domain_out    domain resets, active-high: [0]=20M [1]=25M [2]=50M [3]=logic
//   ready_out         all domains released and lock healthy
//   fail_out          retry budget exhausted
//   retry_cnt_out     failed attempts in the current sequence
//   state_out         FSM state code (RST=0 WAIT_LOCK=1 STABLE=2 RELEASE=3 RUN=4 FAIL=5)
//   lock_loss_cnt_out RUN-to-RST lock-loss count, saturating
//                     (only present when MMCM_LOCK_LOSS_CNT_EN is defined)
//
// Optional feature macro: MMCM_LOCK_LOSS_CNT_EN

module mmcm_rst_seq #(
  parameter int unsigned RST_PULSE_CYC    = 16,
  parameter int unsigned LOCK_TIMEOUT_CYC = 200000,
  parameter int unsigned LOCK_STABLE_CYC  = 1024,
  parameter int unsigned STAGGER_CYC      = 64,
  parameter int unsigned MAX_RETRY        = 7,
  parameter int unsigned CNT_W            = 20
) (
  input  logic        clk_gloal_in,
  input  logic        hardware_rst_in,
  input  logic        soft_rst_req_in,
  input  logic        mmcm_locked_in,
  output logic        mmcm_rst_out,
  output logic [3:0]  rst_domain_out,
  output logic        ready_out,
  output logic        fail_out,
  output logic [2:0]  retry_cnt_out,
`ifdef MMCM_LOCK_LOSS_CNT_EN
  output logic [15:0] lock_loss_cnt_out,
  output logic [2:0]  state_out
`else
  output logic [2:0]  state_out
`endif
);

  typedef enum logic [2:0] {
    StRst      = 3'd0,
    StWaitLock = 3'd1,
    StStable   = 3'd2,
    StRelease  = 3'd3,
    StRun      = 3'd4,
    StFail     = 3'd5
  } state_e;

  localparam logic [CNT_W-1:0] PulseLast   = CNT_W'(RST_PULSE_CYC - 1);
  localparam logic [CNT_W-1:0] TimeoutLast = CNT_W'(LOCK_TIMEOUT_CYC - 1);
  localparam logic [CNT_W-1:0] StableLast  = CNT_W'(LOCK_STABLE_CYC - 1);
  localparam logic [CNT_W-1:0] ReleaseLast = CNT_W'(4 * STAGGER_CYC - 1);
  localparam logic [2:0]       RetryMax    = 3'(MAX_RETRY);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] timer_q, timer_d;
  logic [2:0]       retry_q, retry_d;
  logic             lock_meta_q, lock_s_q;
  logic             mmcm_rst_q, mmcm_rst_d;
  logic [3:0]       rst_domain_q, rst_domain_d;
  logic             ready_q, ready_d;
  logic             fail_q, fail_d;
  logic             attempt_fail;
  logic             run_lock_lost;

  // Two-flop synchronizer for the asynchronous LOCKED input.
  always_ff @(posedge clk_gloal_in or posedge hardware_rst_in) begin
    if (hardware_rst_in) begin
      lock_meta_q <= 1'b0;
      lock_s_q    <= 1'b0;
    end else begin
      lock_meta_q <= mmcm_locked_in;
      lock_s_q    <= lock_meta_q;
    end
  end

  always_comb begin
    state_d       = state_q;
    timer_d       = timer_q;
    retry_d       = retry_q;
    attempt_fail  = 1'b0;
    run_lock_lost = 1'b0;

    unique case (state_q)
      StRst: begin
        if (timer_q == PulseLast) state_d = StWaitLock;
        else                      timer_d = timer_q + 1'b1;
      end
      StWaitLock: begin
        // Lock wins over a simultaneous timeout.
        if (lock_s_q)                    state_d      = StStable;
        else if (timer_q == TimeoutLast) attempt_fail = 1'b1;
        else                             timer_d      = timer_q + 1'b1;
      end
      StStable: begin
        if (!lock_s_q)                  attempt_fail = 1'b1;
        else if (timer_q == StableLast) state_d      = StRelease;
        else                            timer_d      = timer_q + 1'b1;
      end
      StRelease: begin
        if (!lock_s_q)                   attempt_fail = 1'b1;
        else if (timer_q == ReleaseLast) state_d      = StRun;
        else                             timer_d      = timer_q + 1'b1;
      end
      StRun: begin
        if (!lock_s_q) begin
          state_d       = StRst;
          run_lock_lost = 1'b1;
        end
      end
      StFail: begin
        state_d = StFail;
      end
      default: state_d = StRst;
    endcase

    // Shared retry budget; the counter therefore saturates at MAX_RETRY.
    if (attempt_fail) begin
      if (retry_q < RetryMax) begin
        retry_d = retry_q + 1'b1;
        state_d = StRst;
      end else begin
        state_d = StFail;
      end
    end

    if (state_d == StRun) retry_d = '0;

    if (soft_rst_req_in) begin
      state_d       = StRst;
      retry_d       = '0;
      run_lock_lost = 1'b0;
    end

    // Timer restarts on any state change and on a soft request (restarts the RST pulse).
    if ((state_d != state_q) || soft_rst_req_in) timer_d = '0;

    mmcm_rst_d = (state_d == StRst) || (state_d == StFail);
    fail_d     = (state_d == StFail);
    ready_d    = (state_d == StRun);

    unique case (state_d)
      StRun: rst_domain_d = 4'h0;
      StRelease: begin
        // Bit k clears on the edge that ends RELEASE cycle (k+1)*STAGGER_CYC.
        for (int k = 0; k < 4; k++) begin
          rst_domain_d[k] = (timer_d < CNT_W'((k + 1) * STAGGER_CYC));
        end
      end
      default: rst_domain_d = 4'hF;
    endcase
  end

  always_ff @(posedge clk_gloal_in or posedge hardware_rst_in) begin
    if (hardware_rst_in) begin
      state_q      <= StRst;
      timer_q      <= '0;
      retry_q      <= '0;
      mmcm_rst_q   <= 1'b1;
      rst_domain_q <= 4'hF;
      ready_q      <= 1'b0;
      fail_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      timer_q      <= timer_d;
      retry_q      <= retry_d;
      mmcm_rst_q   <= mmcm_rst_d;
      rst_domain_q <= rst_domain_d;
      ready_q      <= ready_d;
      fail_q       <= fail_d;
    end
  end

  assign mmcm_rst_out   = mmcm_rst_q;
  assign rst_domain_out = rst_domain_q;
  assign ready_out      = ready_q;
  assign fail_out       = fail_q;
  assign retry_cnt_out  = retry_q;
  assign state_out      = state_q;

`ifdef MMCM_LOCK_LOSS_CNT_EN
  logic [15:0] lock_loss_q;

  // Not cleared by soft requests; only hardware reset clears it.
  always_ff @(posedge clk_gloal_in or posedge hardware_rst_in) begin
    if (hardware_rst_in) begin
      lock_loss_q <= '0;
    end else if (run_lock_lost && (lock_loss_q != 16'hFFFF)) begin
      lock_loss_q <= lock_loss_q + 16'd1;
    end
  end

  assign lock_loss_cnt_out = lock_loss_q;
`else
  logic unused_run_lock_lost;
  assign unused_run_lock_lost = run_lock_lost;
`endif

endmodule

// File: tb/tb_mmcm_rst_seq.sv
// Directed bench for mmcm_rst_seq with short timing parameters.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_mmcm_rst_seq;

  logic        clk = 1'b0;
  logic        hw_rst;
  logic        soft_req;
  logic        locked;
  logic        mmcm_rst;
  logic [3:0]  rst_domain;
  logic        ready;
  logic        fail;
  logic [2:0]  retry_cnt;
  logic [2:0]  state;
`ifdef MMCM_LOCK_LOSS_CNT_EN
  logic [15:0] lock_loss_cnt;
`endif

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  mmcm_rst_seq #(
    .RST_PULSE_CYC   (4),
    .LOCK_TIMEOUT_CYC(100),
    .LOCK_STABLE_CYC (8),
    .STAGGER_CYC     (2),
    .MAX_RETRY       (2),
    .CNT_W           (20)
  ) dut (
    .clk_gloal_in     (clk),
    .hardware_rst_in  (hw_rst),
    .soft_rst_req_in  (soft_req),
    .mmcm_locked_in   (locked),
    .mmcm_rst_out     (mmcm_rst),
    .rst_domain_out   (rst_domain),
    .ready_out        (ready),
    .fail_out         (fail),
    .retry_cnt_out    (retry_cnt),
`ifdef MMCM_LOCK_LOSS_CNT_EN
    .lock_loss_cnt_out(lock_loss_cnt),
`endif
    .state_out        (state)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Full output vector check: {state, mmcm_rst, rst_domain, ready, fail, retry}
  task automatic check_all(input string tag, input logic [2:0] st, input logic mr,
                           input logic [3:0] dom, input logic rdy, input logic fl,
                           input logic [2:0] rc);
    check({tag, ".state"}, 32'(state), 32'(st));
    check({tag, ".mmcm_rst"}, 32'(mmcm_rst), 32'(mr));
    check({tag, ".rst_domain"}, 32'(rst_domain), 32'(dom));
    check({tag, ".ready"}, 32'(ready), 32'(rdy));
    check({tag, ".fail"}, 32'(fail), 32'(fl));
    check({tag, ".retry"}, 32'(retry_cnt), 32'(rc));
  endtask

  initial begin
    hw_rst   = 1'b1;
    soft_req = 1'b0;
    locked   = 1'b0;
    step(2);
    check_all("reset", 3'd0, 1'b1, 4'hF, 1'b0, 1'b0, 3'd0);
`ifdef MMCM_LOCK_LOSS_CNT_EN
    check("reset.lock_loss", 32'(lock_loss_cnt), 32'd0);
`endif

    // ---- Clean bring-up ----
    hw_rst = 1'b0;
    step(3);
    check("bringup.rst_pulse_hi", 32'(mmcm_rst), 32'd1);
    step(1);
    check("bringup.rst_pulse_lo", 32'(mmcm_rst), 32'd0);
    check("bringup.wait_state", 32'(state), 32'd1);
    step(10);
    locked = 1'b1;
    step(2);
    check("bringup.still_wait", 32'(state), 32'd1);
    step(1);
    check("bringup.stable", 32'(state), 32'd2);
    step(8);
    check_all("bringup.rel0", 3'd3, 1'b0, 4'hF, 1'b0, 1'b0, 3'd0);
    step(1);
    check("bringup.dom_F", 32'(rst_domain), 32'hF);
    step(1);
    check("bringup.dom_E", 32'(rst_domain), 32'hE);
    step(2);
    check("bringup.dom_C", 32'(rst_domain), 32'hC);
    step(2);
    check("bringup.dom_8", 32'(rst_domain), 32'h8);
    step(1);
    check("bringup.dom_8_hold", 32'(rst_domain), 32'h8);
    check("bringup.ready_lo", 32'(ready), 32'd0);
    step(1);
    check_all("bringup.run", 3'd4, 1'b0, 4'h0, 1'b1, 1'b0, 3'd0);

    // ---- Lock loss in RUN ----
    locked = 1'b0;
    step(2);
    check("runloss.still_run", 32'(ready), 32'd1);
    step(1);
    check_all("runloss.rst", 3'd0, 1'b1, 4'hF, 1'b0, 1'b0, 3'd0);
`ifdef MMCM_LOCK_LOSS_CNT_EN
    check("runloss.lock_loss", 32'(lock_loss_cnt), 32'd1);
`endif

    // ---- Timeout and retries (lock stays low) ----
    step(4);
    check("timeout.wait1", 32'(state), 32'd1);
    check("timeout.mmcm_lo1", 32'(mmcm_rst), 32'd0);
    step(99);
    check("timeout.wait1_end", 32'(state), 32'd1);
    step(1);
    check_all("timeout.rst2", 3'd0, 1'b1, 4'hF, 1'b0, 1'b0, 3'd1);
    step(4);
    check("timeout.wait2", 32'(state), 32'd1);
    step(100);
    check_all("timeout.rst3", 3'd0, 1'b1, 4'hF, 1'b0, 1'b0, 3'd2);
    step(4);
    check("timeout.wait3", 32'(state), 32'd1);
    step(100);
    check_all("timeout.fail", 3'd5, 1'b1, 4'hF, 1'b0, 1'b1, 3'd2);
    step(5);
    check("timeout.fail_hold", 32'(state), 32'd5);

    // ---- Soft request from FAIL ----
    soft_req = 1'b1;
    step(1);
    soft_req = 1'b0;
    check_all("soft_fail", 3'd0, 1'b1, 4'hF, 1'b0, 1'b0, 3'd0);

    // ---- Glitch in STABLE ----
    locked = 1'b1;
    step(5);
    check("glitch.stable", 32'(state), 32'd2);
    step(3);
    locked = 1'b0;
    step(1);
    locked = 1'b1;
    step(1);
    check("glitch.still_stable", 32'(state), 32'd2);
    step(1);
    check_all("glitch.rst", 3'd0, 1'b1, 4'hF, 1'b0, 1'b0, 3'd1);
    step(20);
    check("glitch.release", 32'(state), 32'd3);
    check("glitch.retry_rel", 32'(retry_cnt), 32'd1);
    step(1);
    check_all("glitch.run", 3'd4, 1'b0, 4'h0, 1'b1, 1'b0, 3'd0);

    // ---- Soft request from RUN, then during RELEASE after bit0 cleared ----
    soft_req = 1'b1;
    step(1);
    soft_req = 1'b0;
    check_all("soft_run", 3'd0, 1'b1, 4'hF, 1'b0, 1'b0, 3'd0);
`ifdef MMCM_LOCK_LOSS_CNT_EN
    check("soft_run.lock_loss", 32'(lock_loss_cnt), 32'd1);
`endif
    step(13);
    check("soft_rel.release", 32'(state), 32'd3);
    step(2);
    check("soft_rel.dom_E", 32'(rst_domain), 32'hE);
    soft_req = 1'b1;
    step(1);
    soft_req = 1'b0;
    check_all("soft_rel", 3'd0, 1'b1, 4'hF, 1'b0, 1'b0, 3'd0);

    // ---- Async reset mid-RELEASE ----
    step(15);
    check("async.dom_E", 32'(rst_domain), 32'hE);
    step(2);
    check("async.dom_C", 32'(rst_domain), 32'hC);
    #2;
    hw_rst = 1'b1;
    #1;
    check_all("async", 3'd0, 1'b1, 4'hF, 1'b0, 1'b0, 3'd0);
`ifdef MMCM_LOCK_LOSS_CNT_EN
    check("async.lock_loss", 32'(lock_loss_cnt), 32'd0);
`endif
    step(2);
    hw_rst = 1'b0;
    step(1);
    check("async.after_release", 32'(mmcm_rst), 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
